// File: rtl/multiport_register_file.sv
// Parametrised register file: NUM_WR write lanes, NUM_RD combinational read ports,
// optional write-to-read bypass and a per-register pending (scoreboard) bit.
module multiport_register_file #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic [AW-1:0]     rd_addr [NUM_RD],
  output logic [DATA_W-1:0] rd_data [NUM_RD],
  output logic              rd_busy [NUM_RD],
  input  logic              wr_en   [NUM_WR],
  input  logic [AW-1:0]     wr_addr [NUM_WR],
  input  logic [DATA_W-1:0] wr_data [NUM_WR],
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [DEPTH-1:0]  pending
);

  logic [DATA_W-1:0] regs [DEPTH];

  // NOTE: the whole array is reset because reset must clear architectural state
  // without a clock; this prevents mapping onto RAM macros, which is accepted here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking updates in lane order, so the last (highest) lane to
      // target an address is the one that lands; the reserve follows and wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w] != '0) begin
          regs[wr_addr[w]]    <= wr_data[w];
          pending[wr_addr[w]] <= 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) pending[rsv_addr] <= 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic              hit;
    logic [DATA_W-1:0] fwd;

    // NOTE: blocking assignments with defaults first keep this purely combinational.
    always_comb begin
      hit = 1'b0;
      fwd = regs[rd_addr[r]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w] == rd_addr[r]) begin
            hit = 1'b1;
            fwd = wr_data[w];
          end
        end
      end
    end

    // Register 0 and the reset window both force a clean zero, bypass included.
    assign rd_data[r] = (!rst && rd_addr[r] != '0) ? fwd : '0;
    assign rd_busy[r] = !rst && rd_addr[r] != '0 && pending[rd_addr[r]] && !hit;
  end

`ifndef SYNTHESIS
  always @(negedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && !rst) $display("@%h: $%0d <= %h", pc, wr_addr[w], wr_data[w]);
    end
  end
`endif

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the pipelined core. It generalises the single-write, dual-read register file with a configurable number of read and write ports, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit. Decode uses it for operand fetch and hazard detection. Writeback lanes use it for result retirement.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `DEPTH`, 32: number of registers; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `NUM_RD`, 2: read ports, 1–4.
- `NUM_WR`, 2: write ports, 1–4.
- `BYPASS`, 1: 1 = a read returns the same-cycle write data; 0 = a read returns stored contents only.

Ports:
- `clk`  in  1: single clock, posedge-active.
- `rst`  in  1: reset, asynchronous, active-high.
- `pc`  in  32: PC of the retiring instruction; used only for the simulation trace.
- `rd_addr[NUM_RD]`  in  AW: read addresses.
- `rd_data[NUM_RD]`  out  DATA_W: read data, combinational.
- `rd_busy[NUM_RD]`  out  1: the addressed register has a pending producer.
- `wr_en[NUM_WR]`  in  1: write enable per lane.
- `wr_addr[NUM_WR]`  in  AW: write address per lane.
- `wr_data[NUM_WR]`  in  DATA_W: write data per lane.
- `rsv_en`  in  1: reserve request; marks `rsv_addr` as pending.
- `rsv_addr`  in  AW: register to reserve.
- `pending`  out  DEPTH: raw scoreboard vector.

## Operation
- Register 0 is hardwired to zero.
  - Writes to register 0 are discarded.
  - Reserves of register 0 are ignored.
  - Reads of register 0 return 0 and `rd_busy` = 0.
- Write lanes:
  - A write commits at the posedge when `wr_en` = 1.
  - When several enabled lanes target the same address, the highest lane index wins.
  - Every enabled lane that targets a nonzero address clears that register's `pending` bit.
- Reserve:
  - `rsv_en` sets `pending[rsv_addr]` at the posedge.
  - When a reserve and a write hit the same address in one cycle, the reserve wins: the register is written and `pending` stays 1, because a new producer is in flight.
- Read, `BYPASS` = 1:
  - If any enabled lane targets `rd_addr` (nonzero), `rd_data` is the winning lane's `wr_data`. Otherwise `rd_data` is the stored value.
  - `rd_busy` is `pending[rd_addr]` AND NOT (any enabled write lane targets `rd_addr`).
- Read, `BYPASS` = 0:
  - `rd_data` is the stored value.
  - `rd_busy` is `pending[rd_addr]`.
- Trace (simulation only):
  - On the negedge, for each enabled lane with `rst` = 0, print `@<pc>: $<addr> <= <data>`, in lane order.
  - Lanes targeting register 0 are printed too.

## Timing
- Reset: asserting `rst` immediately clears all registers and `pending`, with no clock needed. While `rst` is high:
  - `rd_data` = 0.
  - `rd_busy` = 0.
  - `pending` = 0.
  - Writes and reserves are ignored.
- Reset can arrive in the middle of operation. Release is synchronous to the next posedge, and the first write can occur on the first posedge after release.
- Write latency:
  - `BYPASS` = 1: 0 cycles to read ports, 1 cycle to stored state.
  - `BYPASS` = 0: 1 cycle.
- Reserve latency: `pending` and `rd_busy` rise in the cycle after `rsv_en`. There is no same-cycle forwarding of a reserve.
- No handshake back-pressure exists. Every input is sampled every cycle.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, then assert `rst` between clock edges. Require `rd_data` = 0 immediately, `pending` = 0, and no write in the cycle of release.
- Write conflict, `NUM_WR` = 2: lane0 writes r7 = 0x1111 and lane1 writes r7 = 0x2222 in the same cycle. Require r7 = 0x2222 on the next cycle, and `rd_data` = 0x2222 in the same cycle when `BYPASS` = 1.
- Zero register: write r0 = 0xFFFF_FFFF and reserve r0. Require `rd_data` = 0 and `rd_busy` = 0. The trace still prints the write.
- Scoreboard:
  - Reserve r3 at cycle 0. Require `rd_busy` = 1 at cycle 1.
  - Lane1 writes r3 = 0xABCD at cycle 2. Require `rd_busy` = 0 and `rd_data` = 0xABCD combinationally at cycle 2 (`BYPASS` = 1), and `pending[3]` = 0 at cycle 3.
- Reserve/write collision: `rsv_en` to r9 together with a write of r9 = 0x55. Require r9 = 0x55 and `pending[9]` = 1 afterwards.
- `BYPASS` = 0, `DATA_W` = 16, `DEPTH` = 8, `NUM_RD` = 3: read r2 on three ports while writing r2 = 0x00A5. Require the old value 0 on all three ports that cycle and 0x00A5 on all three ports the next cycle.
